// File: rtl/layer_weight_feeder_pkg.sv
// rtl/layer_weight_feeder_pkg.sv - shared layer dimensions and feeder FSM encoding
package layer_weight_feeder_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_INPUT_NODES  = 24;
   localparam int DEF_OUTPUT_NODES = 128;
   localparam int DEF_ADDR_WIDTH   = 5;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } feeder_state_t;

endpackage

// File: rtl/layer_weight_feeder_weight_row_mem.sv
// rtl/layer_weight_feeder_weight_row_mem.sv - synchronous-read row array, read-before-write on collision
module weight_row_mem
   import layer_weight_feeder_pkg::*;
#(
   parameter int ROW_WIDTH  = DEF_DATA_WIDTH * DEF_OUTPUT_NODES,
   parameter int DEPTH      = DEF_INPUT_NODES,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [ROW_WIDTH-1:0]  wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ROW_WIDTH-1:0]  rd_data
);

   logic [ROW_WIDTH-1:0] r_mem [DEPTH];
   logic [ROW_WIDTH-1:0] r_rd_data;
   logic                 w_wr_ok;

   // Out-of-range addresses are dropped rather than aliased onto a real row.
   assign w_wr_ok = wr_en && ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_mem[wr_addr] <= wr_data;
   end

   // Storage is not reset; only the output register is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rd_data <= '0;
      else if (rd_en)
         r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/layer_weight_feeder.sv
// rtl/layer_weight_feeder.sv - streams weight rows INPUT_NODES-1 down to 0 to the layer
// Optional: WEIGHT_CHECKSUM_EN adds an XOR checksum of every streamed row.
module layer_weight_feeder
   import layer_weight_feeder_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int INPUT_NODES  = DEF_INPUT_NODES,
   parameter int OUTPUT_NODES = DEF_OUTPUT_NODES,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] wr_data,
   input  logic                             start,
   input  logic                             hold,
   output logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
   output logic                             weights_valid,
   output logic [ADDR_WIDTH-1:0]            row_index,
   output logic                             busy,
   output logic                             done
`ifdef WEIGHT_CHECKSUM_EN
   ,output logic [DATA_WIDTH*OUTPUT_NODES-1:0] checksum
`endif
);

   localparam int                    ROW_WIDTH = DATA_WIDTH * OUTPUT_NODES;
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(INPUT_NODES - 1);

   feeder_state_t           r_state;
   logic [ADDR_WIDTH-1:0]   r_rd_row;
   logic [ADDR_WIDTH-1:0]   r_row_index;
   logic                    r_valid;
   logic                    r_done;
   logic                    r_busy;
   logic                    w_rd_en;
   logic [ROW_WIDTH-1:0]    w_rd_data;

   assign w_rd_en = (r_state == ST_STREAM) && !hold;

   weight_row_mem #(
      .ROW_WIDTH  (ROW_WIDTH),
      .DEPTH      (INPUT_NODES),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (w_rd_en),
      .rd_addr (r_rd_row),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_rd_row    <= LAST_ROW;
         r_row_index <= '0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid <= w_rd_en;
         r_done  <= w_rd_en && (r_rd_row == '0);
         if (w_rd_en)
            r_row_index <= r_rd_row;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_STREAM;
                  r_busy   <= 1'b1;
                  r_rd_row <= LAST_ROW;
               end
            end
            ST_STREAM: begin
               // Leaving on the row-0 read lets busy drop before the done beat.
               if (!hold) begin
                  if (r_rd_row == '0) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_rd_row <= r_rd_row - 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign weights       = w_rd_data;
   assign weights_valid = r_valid;
   assign row_index     = r_row_index;
   assign busy          = r_busy;
   assign done          = r_done;

`ifdef WEIGHT_CHECKSUM_EN
   logic [ROW_WIDTH-1:0] r_checksum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_checksum <= '0;
      else if ((r_state == ST_IDLE) && start)
         r_checksum <= '0;
      else if (r_valid)
         r_checksum <= r_checksum ^ w_rd_data;
   end

   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_layer_weight_feeder.sv
// tb/tb_layer_weight_feeder.sv - directed table-driven bench for layer_weight_feeder
module tb_layer_weight_feeder;
   import layer_weight_feeder_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int IN = DEF_INPUT_NODES;
   localparam int ON = DEF_OUTPUT_NODES;
   localparam int AW = DEF_ADDR_WIDTH;
   localparam int W  = DW * ON;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic [W-1:0]  weights;
   logic          weights_valid;
   logic [AW-1:0] row_index;
   logic          busy;
   logic          done;
`ifdef WEIGHT_CHECKSUM_EN
   logic [W-1:0]  checksum;
`endif

   layer_weight_feeder dut (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .hold          (hold),
      .weights       (weights),
      .weights_valid (weights_valid),
      .row_index     (row_index),
      .busy          (busy),
      .done          (done)
`ifdef WEIGHT_CHECKSUM_EN
      ,.checksum     (checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic          start;
      logic          wr;
      logic [AW-1:0] wr_addr;
      logic [7:0]    wr_byte;
      logic          v;
      logic [AW-1:0] row;
      logic          busy;
      logic          done;
   } vec_t;

   vec_t       tbl [27];
   logic [7:0] exp_mem [IN];

   function automatic logic [W-1:0] rep(input logic [DW-1:0] b);
      return {ON{b}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got byte0 %0h byte%0d %0h expected row of %0h", name, act[7:0], ON-1, act[W-1 -: 8], exp[7:0]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plain 27-cycle stream: reads at cycles 1..24, valid 2..25 (rows 23..0), done at 25.
   task automatic build(input int mid_start, input bit tail_start, input bit collide);
      for (int c = 0; c < 27; c++) begin
         tbl[c].start   = (c == 0) || (mid_start > 0 && (c == mid_start || c == 24)) || (tail_start && c == 26);
         tbl[c].wr      = collide && (c == 14);
         tbl[c].wr_addr = AW'(10);
         tbl[c].wr_byte = 8'hAA;
         tbl[c].v       = (c >= 2) && (c <= 25);
         tbl[c].row     = (c >= 2 && c <= 25) ? AW'(25 - c) : '0;
         tbl[c].busy    = (c >= 1) && (c <= 24);
         tbl[c].done    = (c == 25);
      end
   endtask

   task automatic run(input int first, input string tag);
      for (int c = first; c < 27; c++) begin
         start   = tbl[c].start;
         wr_en   = tbl[c].wr;
         wr_addr = tbl[c].wr_addr;
         wr_data = rep(tbl[c].wr_byte);
         chk($sformatf("%s c%0d valid", tag, c), 64'(weights_valid), 64'(tbl[c].v));
         chk($sformatf("%s c%0d busy", tag, c), 64'(busy), 64'(tbl[c].busy));
         chk($sformatf("%s c%0d done", tag, c), 64'(done), 64'(tbl[c].done));
         if (c >= 2) begin
            chk($sformatf("%s c%0d row", tag, c), 64'(row_index), 64'(tbl[c].row));
            chk_w($sformatf("%s c%0d weights", tag, c), weights, rep(exp_mem[tbl[c].row]));
         end
         step();
         start = 1'b0;
         wr_en = 1'b0;
      end
   endtask

   initial begin
      int exp_row;
      step();
      step();
      chk("reset weights_valid", 64'(weights_valid), 64'd0);
      chk("reset row_index", 64'(row_index), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk_w("reset weights", weights, '0);
      reset = 1'b0;
      step();

      for (int r = 0; r < IN; r++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(r);
         wr_data = rep(8'(r + 1));
         exp_mem[r] = 8'(r + 1);
         step();
      end
      wr_addr = AW'(30);
      wr_data = rep(8'hFF);
      step();
      wr_addr = AW'(IN);
      step();
      wr_en = 1'b0;
      hold  = 1'b1;
      step();
      chk("idle hold valid", 64'(weights_valid), 64'd0);
      chk("idle hold busy", 64'(busy), 64'd0);
      hold = 1'b0;

      build(0, 1'b0, 1'b0);
      run(0, "order");
`ifdef WEIGHT_CHECKSUM_EN
      chk_w("checksum after done", checksum, rep(8'h18));
`endif

      build(10, 1'b1, 1'b0);
      run(0, "midstart");
      build(0, 1'b0, 1'b1);
      run(1, "collide");
      exp_mem[10] = 8'hAA;
      build(0, 1'b0, 1'b0);
      run(0, "aftercol");

      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 28; c++) begin
         hold = (c == 5) || (c == 6);
         if (c <= 5)       exp_row = 25 - c;
         else if (c <= 7)  exp_row = 20;
         else if (c <= 27) exp_row = 27 - c;
         else              exp_row = 0;
         chk($sformatf("stall c%0d valid", c), 64'(weights_valid),
             64'(c >= 2 && c <= 27 && c != 6 && c != 7));
         chk($sformatf("stall c%0d busy", c), 64'(busy), 64'(c <= 26));
         chk($sformatf("stall c%0d done", c), 64'(done), 64'(c == 27));
         if (c >= 2) begin
            chk($sformatf("stall c%0d row", c), 64'(row_index), 64'(exp_row));
            chk_w($sformatf("stall c%0d weights", c), weights, rep(exp_mem[exp_row]));
         end
         step();
      end
      hold = 1'b0;

      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 9; c++) step();
      chk("pre-reset valid", 64'(weights_valid), 64'd1);
      chk("pre-reset row", 64'(row_index), 64'd16);
      reset = 1'b1;
      #1;
      chk("midreset valid", 64'(weights_valid), 64'd0);
      chk("midreset row", 64'(row_index), 64'd0);
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset done", 64'(done), 64'd0);
      chk_w("midreset weights", weights, '0);
      step();
      reset = 1'b0;
      step();
      build(0, 1'b0, 1'b0);
      run(0, "postreset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
